logic_gates_bist: RTL and testbench
===================================

# logic_gates_bist

Self-test sequencer for the `logic_gates` combinational block, Z = (~(A|B) & C & D) | ((~E|F) & G). On a start request it sweeps all 128 input vectors into the block. It holds each vector for a programmable settle time, samples Z, and compares it against an internal golden model. It then reports pass/fail, an error count and the first failing vector. It sits beside the `logic_gates` instance and owns its seven inputs during a run.

## Interface
- SETTLE, default 1: cycles each vector is held before Z is sampled; legal range 1..15.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- dut_z  input  1  Z output of the `logic_gates` instance.
- vec  output  7  drives the DUT: vec[6]=A, vec[5]=B, vec[4]=C, vec[3]=D, vec[2]=E, vec[1]=F, vec[0]=G.
- busy  output  1  high while a sweep is in progress.
- done  output  1  level; high in DONE until the next start or rst.
- pass  output  1  done & (err_count == 0).
- err_count  output  8  number of mismatching vectors in the last sweep, range 0..128.
- first_fail  output  7  lowest vector index that mismatched.
- first_fail_valid  output  1  first_fail holds a captured index.

## Operation
- States:
  - IDLE: after reset.
  - DRIVE: vec is stable; the settle counter runs.
  - CHECK: compare dut_z with the golden value.
  - DONE: sweep finished; results held.
- IDLE --start--> DRIVE:
  - vec=0, err_count=0, first_fail_valid=0, settle counter=0.
- DRIVE:
  - Counter increments each cycle.
  - When counter == SETTLE-1, go to CHECK.
  - vec is unchanged throughout.
- CHECK:
  - Compute golden = (~(vec[6]|vec[5]) & vec[4] & vec[3]) | ((~vec[2]|vec[1]) & vec[0]).
  - On mismatch, err_count += 1.
  - On mismatch with first_fail_valid==0, capture first_fail=vec and set first_fail_valid.
  - If vec==127, go to DONE. Otherwise vec += 1, clear the counter, go to DRIVE.
- DONE --start--> DRIVE: restarts exactly as from IDLE; previous results are cleared on that edge.
- start is ignored in DRIVE and CHECK; no queuing.
- err_count cannot overflow: maximum 128 fits in 8 bits, so no saturation logic is needed.
- vec is a 7-bit counter. The increment from 127 never occurs, because CHECK at 127 exits to DONE. vec holds 127 in DONE.
- busy = (state==DRIVE) | (state==CHECK).

## Timing
- Reset values: vec=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0; state=IDLE.
- rst has priority over start and over every state, including mid-sweep. The run is abandoned and all outputs return to reset values on the next edge.
- All outputs are registered except pass. pass is combinational from done and err_count, both registered.
- dut_z is sampled in the CHECK cycle. The DUT is treated as purely combinational from vec, so the DUT sees each vector for SETTLE+1 cycles before its Z is compared.
- Per-vector cost is SETTLE+1 cycles.
- If start is sampled high at edge k:
  - busy is high from edge k to edge k+128·(SETTLE+1).
  - done rises at edge k+128·(SETTLE+1).
  - For SETTLE=1, done rises 256 cycles after the start edge.
- err_count and first_fail update at the CHECK edge and are stable while done=1.

## Test plan
- Correct DUT connected, SETTLE=1, pulse start:
  - done rises 256 cycles later; err_count=0, pass=1, first_fail_valid=0; vec visits 0..127 in order, each held 2 cycles.
- dut_z tied 0:
  - err_count=53, pass=0, first_fail=1, first_fail_valid=1.
- dut_z tied 1:
  - err_count=75, first_fail=0.
- dut_z = inverted correct Z:
  - err_count=128, first_fail=0.
- SETTLE=3, correct DUT:
  - done after 512 cycles; start re-pulsed mid-sweep is ignored (vec continues monotonically).
  - start pulsed in DONE restarts with cleared results.
- rst asserted at cycle 50 of a sweep:
  - next edge has all outputs at reset values and state=IDLE; a new start then completes a full 128-vector sweep with correct counts.

Source files
------------

// File: rtl/logic_gates_bist.sv
// Purpose: built-in self-test sweep of the logic_gates block over all 128 input vectors.
// Latency: SETTLE+1 cycles per vector, so done rises 128*(SETTLE+1) edges after start.
// Backpressure: none; start is only accepted in IDLE or DONE and ignored mid-sweep.
module logic_gates_bist #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_z,
    output logic [6:0] vec,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [6:0] first_fail,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [6:0] vec_nx;
    logic [7:0] err_nx;
    logic [6:0] ff_nx;
    logic       ffv_nx;
    logic       golden;

    // Reference model of the block under test, evaluated on the vector being driven.
    always_comb begin
        golden = (~(vec[6] | vec[5]) & vec[4] & vec[3]) | ((~vec[2] | vec[1]) & vec[0]);
    end

    // Next-state and next-result logic; every register holds unless a state says otherwise.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        vec_nx   = vec;
        err_nx   = err_count;
        ff_nx    = first_fail;
        ffv_nx   = first_fail_valid;
        case (state)
            IDLE, DONE: begin
                // A new run wipes the previous results on the same edge it starts.
                if (start) begin
                    state_nx = DRIVE;
                    cnt_nx   = 4'd0;
                    vec_nx   = 7'd0;
                    err_nx   = 8'd0;
                    ff_nx    = 7'd0;
                    ffv_nx   = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nx = CHECK;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            CHECK: begin
                if (dut_z != golden) begin
                    // At most 128 mismatches, so the 8-bit count never wraps.
                    err_nx = err_count + 8'd1;
                    if (!first_fail_valid) begin
                        ff_nx  = vec;
                        ffv_nx = 1'b1;
                    end
                end
                // Vector 127 ends the sweep, so vec never wraps and stays at 127 in DONE.
                if (vec == 7'd127) begin
                    state_nx = DONE;
                end else begin
                    vec_nx   = vec + 7'd1;
                    cnt_nx   = 4'd0;
                    state_nx = DRIVE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and result registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            vec              <= 7'd0;
            err_count        <= 8'd0;
            first_fail       <= 7'd0;
            first_fail_valid <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            vec              <= vec_nx;
            err_count        <= err_nx;
            first_fail       <= ff_nx;
            first_fail_valid <= ffv_nx;
            busy             <= (state_nx == DRIVE) || (state_nx == CHECK);
            done             <= (state_nx == DONE);
        end
    end

    // Pass is the only combinational output, derived from registered done and count.
    always_comb begin
        pass = done & (err_count == 8'd0);
    end

endmodule

// File: tb/tb_logic_gates_bist.sv
// Bench for logic_gates_bist: two instances (SETTLE=1 and SETTLE=3), each fed by a
// behavioural stand-in for logic_gates whose Z can be correct, stuck, or inverted.
// Stimulus pushes hand-computed results per run; a negedge monitor checks them at done.
module tb_logic_gates_bist;

    typedef struct {
        int   err;
        int   ff;
        logic ffv;
        int   lat;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] start;
    logic [1:0] z;
    logic [6:0] vec_a  [2];
    logic       busy_a [2];
    logic       done_a [2];
    logic       pass_a [2];
    logic [7:0] err_a  [2];
    logic [6:0] ff_a   [2];
    logic       ffv_a  [2];

    int   cyc = 0;
    int   mode [2];
    int   st [2];
    logic armed [2];
    logic prev_done [2];
    logic rst_seen [2];
    int   seq_bad [2];
    int   checks = 0;
    int   failures = 0;
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_seen[0] <= rst[0];
        rst_seen[1] <= rst[1];
    end

    function automatic logic gold(input logic [6:0] v);
        return (~(v[6] | v[5]) & v[4] & v[3]) | ((~v[2] | v[1]) & v[0]);
    endfunction

    // Mode 0 correct block, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
    function automatic logic zmodel(input int m, input logic [6:0] v);
        case (m)
            0:       return gold(v);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~gold(v);
        endcase
    endfunction

    assign z[0] = zmodel(mode[0], vec_a[0]);
    assign z[1] = zmodel(mode[1], vec_a[1]);

    logic_gates_bist #(.SETTLE(1)) u_bist0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .dut_z(z[0]),
        .vec(vec_a[0]), .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]),
        .err_count(err_a[0]), .first_fail(ff_a[0]), .first_fail_valid(ffv_a[0])
    );

    logic_gates_bist #(.SETTLE(3)) u_bist1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .dut_z(z[1]),
        .vec(vec_a[1]), .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]),
        .err_count(err_a[1]), .first_fail(ff_a[1]), .first_fail_valid(ffv_a[1])
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int per_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    task automatic mon(input int i);
        int   j;
        int   per;
        exp_t e;
        logic have;
        per = per_of(i);
        j   = cyc - st[i];
        if (rst_seen[i]) begin
            check($sformatf("reset_outputs[%0d]", i),
                  longint'({vec_a[i], busy_a[i], done_a[i], pass_a[i],
                            err_a[i], ff_a[i], ffv_a[i]}), 0);
        end
        if (armed[i]) begin
            if (j == 0) seq_bad[i] = 0;
            if (j >= 0 && j < 128 * per) begin
                if (busy_a[i] !== 1'b1 || done_a[i] !== 1'b0 || vec_a[i] !== 7'(j / per))
                    seq_bad[i]++;
            end
        end
        if (done_a[i] === 1'b1 && prev_done[i] !== 1'b1) begin
            have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done[%0d] actual=done_rose required=no_done", i);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("latency[%0d]", i), longint'(j), longint'(e.lat));
                check($sformatf("vec_sequence_errors[%0d]", i), longint'(seq_bad[i]), 0);
                check($sformatf("final_vec[%0d]", i), longint'(vec_a[i]), 127);
                check($sformatf("err_count[%0d]", i), longint'(err_a[i]), longint'(e.err));
                check($sformatf("first_fail_valid[%0d]", i), longint'(ffv_a[i]), longint'(e.ffv));
                if (e.ffv)
                    check($sformatf("first_fail[%0d]", i), longint'(ff_a[i]), longint'(e.ff));
                check($sformatf("pass[%0d]", i), longint'(pass_a[i]), (e.err == 0) ? 1 : 0);
            end
        end
        prev_done[i] = done_a[i];
    endtask

    // Monitor: samples both instances on the falling edge, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) mon(i);
    end

    task automatic go(input int i, input int m, input int err, input int ff, input logic ffv);
        exp_t e;
        @(posedge clk);
        #1;
        mode[i]  = m;
        start[i] = 1'b1;
        st[i]    = cyc + 1;
        armed[i] = 1'b1;
        e.err = err;
        e.ff  = ff;
        e.ffv = ffv;
        e.lat = 128 * per_of(i);
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst   = 2'b11;
        start = 2'b00;
        mode[0] = 0; mode[1] = 0;
        st[0] = 0; st[1] = 0;
        armed[0] = 1'b0; armed[1] = 1'b0;
        prev_done[0] = 1'b0; prev_done[1] = 1'b0;
        rst_seen[0] = 1'b0; rst_seen[1] = 1'b0;
        seq_bad[0] = 0; seq_bad[1] = 0;
        wait_cycles(3);
        #1 rst = 2'b00;

        // SETTLE=1: correct block, stuck-at-0, stuck-at-1, inverted.
        go(0, 0, 0,   0, 1'b0); wait_cycles(260);
        go(0, 1, 53,  1, 1'b1); wait_cycles(260);
        go(0, 2, 75,  0, 1'b1); wait_cycles(260);
        go(0, 3, 128, 0, 1'b1); wait_cycles(260);

        // Reset mid-sweep abandons the run; a fresh start then completes normally.
        go(0, 0, 0, 0, 1'b0);
        wait_cycles(49);
        #1;
        rst[0]   = 1'b1;
        armed[0] = 1'b0;
        void'(q0.pop_back());
        @(posedge clk);
        #1 rst[0] = 1'b0;
        wait_cycles(2);
        go(0, 1, 53, 1, 1'b1); wait_cycles(260);

        // SETTLE=3: a start pulse mid-sweep must not disturb the running sweep.
        go(1, 0, 0, 0, 1'b0);
        wait_cycles(200);
        #1 start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        wait_cycles(516 - 201);

        // Restart from DONE after a failing run must clear the old results.
        go(1, 3, 128, 0, 1'b1); wait_cycles(516);
        go(1, 0, 0,   0, 1'b0); wait_cycles(516);

        for (int k = 0; k < q0.size(); k++) begin
            checks++;
            failures++;
            $display("FAIL done_missing[0] actual=no_done required=done_rise");
        end
        for (int k = 0; k < q1.size(); k++) begin
            checks++;
            failures++;
            $display("FAIL done_missing[1] actual=no_done required=done_rise");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
